// File: rtl/uart_cmd_responder_pkg.sv
// Shared opcode values and FSM state encoding for the UART command responder.
package uart_cmd_responder_pkg;

   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_AND = 6'b100100;
   localparam logic [5:0] OP_OR  = 6'b100101;
   localparam logic [5:0] OP_XOR = 6'b100110;
   localparam logic [5:0] OP_NOR = 6'b100111;
   localparam logic [5:0] OP_SRA = 6'b000011;
   localparam logic [5:0] OP_SRL = 6'b000010;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_GET_B   = 3'd1,
      ST_GET_OP  = 3'd2,
      ST_EXEC    = 3'd3,
      ST_SEND    = 3'd4,
      ST_WAIT_TX = 3'd5
   } state_t;

endpackage

// File: rtl/uart_cmd_responder_alu.sv
// Combinational integer ALU; unknown opcodes yield zero and raise o_invalid.
module alu
   import uart_cmd_responder_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int OP_WIDTH   = 6
) (
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   input  logic [OP_WIDTH-1:0]   i_op,
   output logic [DATA_WIDTH-1:0] o_result,
   output logic                  o_invalid
);

   // Opcode decode and arithmetic; shift amounts use the full B value
   always_comb begin
      o_result  = {DATA_WIDTH{1'b0}};
      o_invalid = 1'b0;
      case (i_op)
         OP_WIDTH'(OP_ADD): o_result = i_a + i_b;
         OP_WIDTH'(OP_SUB): o_result = i_a - i_b;
         OP_WIDTH'(OP_AND): o_result = i_a & i_b;
         OP_WIDTH'(OP_OR):  o_result = i_a | i_b;
         OP_WIDTH'(OP_XOR): o_result = i_a ^ i_b;
         OP_WIDTH'(OP_NOR): o_result = ~(i_a | i_b);
         OP_WIDTH'(OP_SRA): o_result = $signed(i_a) >>> i_b;
         OP_WIDTH'(OP_SRL): o_result = i_a >> i_b;
         default: begin
            o_result  = {DATA_WIDTH{1'b0}};
            o_invalid = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/uart_cmd_responder.sv
// Collects a three-byte command (A, B, opcode) from the UART receiver,
// evaluates it and hands one result byte to the transmitter.
module uart_cmd_responder
   import uart_cmd_responder_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int OP_WIDTH       = 6,
   parameter int TIMEOUT_CYCLES = 2_000_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_rx_done,
   input  logic [DATA_WIDTH-1:0] i_rx_data,
   input  logic                  i_tx_done,
   output logic                  o_tx_start,
   output logic [DATA_WIDTH-1:0] o_tx_data,
   output logic                  o_busy,
   output logic                  o_err
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   // Timing out on the edge where the counter would reach TIMEOUT_CYCLES-1
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

   state_t                state_r;
   logic [DATA_WIDTH-1:0] a_r;
   logic [DATA_WIDTH-1:0] b_r;
   logic [OP_WIDTH-1:0]   op_r;
   logic [CNT_W-1:0]      timer_r;
   logic                  tx_start_r;
   logic [DATA_WIDTH-1:0] tx_data_r;
   logic                  busy_r;
   logic                  err_r;

   logic [OP_WIDTH-1:0]   alu_op_s;
   logic [DATA_WIDTH-1:0] alu_result_s;
   logic                  alu_invalid_s;

   // The incoming opcode byte is decoded early so a bad opcode flags during EXEC
   always_comb begin
      if (state_r == ST_EXEC) begin
         alu_op_s = op_r;
      end else begin
         alu_op_s = i_rx_data[OP_WIDTH-1:0];
      end
   end

   alu #(
      .DATA_WIDTH (DATA_WIDTH),
      .OP_WIDTH   (OP_WIDTH)
   ) u_alu (
      .i_a       (a_r),
      .i_b       (b_r),
      .i_op      (alu_op_s),
      .o_result  (alu_result_s),
      .o_invalid (alu_invalid_s)
   );

   // Frame sequencing, inter-byte timeout and all registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         a_r        <= {DATA_WIDTH{1'b0}};
         b_r        <= {DATA_WIDTH{1'b0}};
         op_r       <= {OP_WIDTH{1'b0}};
         timer_r    <= {CNT_W{1'b0}};
         tx_start_r <= 1'b0;
         tx_data_r  <= {DATA_WIDTH{1'b0}};
         busy_r     <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         tx_start_r <= 1'b0;
         err_r      <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               timer_r <= {CNT_W{1'b0}};
               if (i_rx_done) begin
                  a_r     <= i_rx_data;
                  state_r <= ST_GET_B;
                  busy_r  <= 1'b1;
               end else begin
                  busy_r  <= 1'b0;
               end
            end
            ST_GET_B: begin
               if (i_rx_done) begin
                  b_r     <= i_rx_data;
                  timer_r <= {CNT_W{1'b0}};
                  state_r <= ST_GET_OP;
               end else if (timer_r == TIMEOUT_LAST) begin
                  timer_r <= {CNT_W{1'b0}};
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                  err_r   <= 1'b1;
               end else begin
                  timer_r <= timer_r + CNT_W'(1);
               end
            end
            ST_GET_OP: begin
               if (i_rx_done) begin
                  op_r    <= i_rx_data[OP_WIDTH-1:0];
                  timer_r <= {CNT_W{1'b0}};
                  err_r   <= alu_invalid_s;
                  state_r <= ST_EXEC;
               end else if (timer_r == TIMEOUT_LAST) begin
                  timer_r <= {CNT_W{1'b0}};
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                  err_r   <= 1'b1;
               end else begin
                  timer_r <= timer_r + CNT_W'(1);
               end
            end
            ST_EXEC: begin
               tx_data_r  <= alu_result_s;
               tx_start_r <= 1'b1;
               err_r      <= i_rx_done;
               state_r    <= ST_SEND;
            end
            ST_SEND: begin
               err_r   <= i_rx_done;
               state_r <= ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
               err_r <= i_rx_done;
               if (i_tx_done) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  state_r <= ST_WAIT_TX;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               timer_r <= {CNT_W{1'b0}};
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign o_tx_start = tx_start_r;
   assign o_tx_data  = tx_data_r;
   assign o_busy     = busy_r;
   assign o_err      = err_r;

endmodule
